// File: rtl/vdp_sprite_divide_table.sv
// vdp_sprite_divide_table: sample_x = floor(x * (16<<bit_shift) / M), clamped to W-1; three pipeline stages.
module vdp_sprite_divide_table (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x,
    input  logic [7:0] reg_mgx,
    input  logic [1:0] bit_shift,
    output logic [6:0] sample_x
);
    logic [23:0] w_rom [256];
    logic [14:0] r1_n;
    logic [23:0] r1_r;
    logic [1:0]  r1_s;
    logic [1:0]  r2_s;
    logic [15:0] r2_q;
    logic [6:0]  w_max;
    // ceil(2^23/M) keeps the error below 1/256 for N < 2^15, so the floor is exact
    for (genvar i = 0; i < 256; i++) begin : g_rom
        localparam int M = (i == 0) ? 256 : i;
        assign w_rom[i] = 24'((2**23 + M - 1) / M);
    end
    assign w_max = {r2_s == 2'd3, r2_s[1], |r2_s, 4'hf};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_n     <= '0;
            r1_r     <= '0;
            r1_s     <= '0;
            r2_q     <= '0;
            r2_s     <= '0;
            sample_x <= '0;
        end else begin
            r1_n     <= 15'(x) << bit_shift << 4;
            r1_r     <= w_rom[reg_mgx];
            r1_s     <= bit_shift;
            r2_q     <= 16'((39'(r1_n) * 39'(r1_r)) >> 23);
            r2_s     <= r1_s;
            sample_x <= (r2_q > 16'(w_max)) ? w_max : r2_q[6:0];
        end
    end
endmodule

// File: tb/tb_vdp_sprite_divide_table.sv
// tb_vdp_sprite_divide_table: directed streams with a queue scoreboard for the sprite divide table.
module tb_vdp_sprite_divide_table;
    logic       clk = 0;
    logic       reset = 1;
    logic [7:0] x = 0;
    logic [7:0] reg_mgx = 0;
    logic [1:0] bit_shift = 0;
    logic [6:0] sample_x;
    int total = 0;
    int passed = 0;

    typedef struct {
        logic       chk;
        logic [6:0] v;
        string      tag;
    } exp_t;
    exp_t sb [$];

    vdp_sprite_divide_table dut (
        .clk(clk), .reset(reset), .x(x), .reg_mgx(reg_mgx),
        .bit_shift(bit_shift), .sample_x(sample_x)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model(input int xi, input int mi, input int si);
        int w = 16 << si;
        int m = (mi == 0) ? 256 : mi;
        int q = (xi * w) / m;
        return 7'((q >= w) ? w - 1 : q);
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    task automatic drive(input int xi, input int mi, input int si, input logic chk,
                         input logic [6:0] v, input string tag);
        exp_t e;
        @(negedge clk);
        if (sb.size() == 3) begin
            e = sb.pop_front();
            if (e.chk) check(e.tag, sample_x, e.v);
        end
        x = 8'(xi);
        reg_mgx = 8'(mi);
        bit_shift = 2'(si);
        sb.push_back('{chk, v, tag});
    endtask

    task automatic step(input int xi, input int mi, input int si);
        drive(xi, mi, si, 1'b1, model(xi, mi, si), $sformatf("model x=%0d m=%0d s=%0d", xi, mi, si));
    endtask

    task automatic step_e(input int xi, input int mi, input int si, input int v);
        drive(xi, mi, si, 1'b1, 7'(v), $sformatf("direct x=%0d m=%0d s=%0d", xi, mi, si));
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 1'b0, 7'd0, "idle");
    endtask

    initial begin
        #12;
        check("reset_state", sample_x, 7'd0);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 20; i++) step_e(i, 16, 0, (i < 16) ? i : 15);
        step_e(5, 16, 1, 10);  step_e(5, 16, 2, 20);  step_e(5, 16, 3, 40);
        step_e(15, 16, 1, 30); step_e(15, 16, 2, 60); step_e(15, 16, 3, 120);
        step_e(16, 16, 1, 31); step_e(16, 16, 2, 63); step_e(20, 16, 3, 127);
        for (int i = 0; i < 25; i++) step(i, 19, 0);
        step_e(10, 19, 0, 8);  step_e(18, 19, 0, 15); step_e(19, 19, 0, 15);
        step_e(18, 19, 3, 121);
        step_e(64, 128, 0, 8);   step_e(64, 128, 1, 16);  step_e(64, 128, 2, 32);  step_e(64, 128, 3, 64);
        step_e(127, 128, 0, 15); step_e(127, 128, 1, 31); step_e(127, 128, 2, 63); step_e(127, 128, 3, 127);
        step_e(128, 128, 0, 15); step_e(255, 128, 3, 127);
        for (int i = 0; i < 256; i++) step(i, 0, 0);
        step_e(17, 0, 0, 1);   step_e(255, 0, 0, 15);
        step_e(200, 0, 3, 100); step_e(255, 0, 3, 127);
        step_e(8, 8, 0, 15); step_e(3, 8, 0, 6); step_e(7, 8, 0, 14);
        for (int m = 64; m < 256; m++) begin
            if (m == 150) begin
                @(negedge clk);
                #2 reset = 1;
                #1 check("reset_async", sample_x, 7'd0);
                @(posedge clk);
                #1 check("reset_hold", sample_x, 7'd0);
                @(negedge clk);
                reset = 0;
                sb.delete();
            end
            for (int xi = 0; xi < 256; xi += 3) step(xi, m, 3);
        end
        drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
